// File: rtl/anim_scheduler_if.sv
// Bundles the vsync/switch inputs and the scroll outputs of anim_scheduler.
// The master side drives sync and switches; the slave side is the scheduler.
interface anim_scheduler_if;
    logic       vsync;
    logic [3:0] speed_sw;
    logic       dir_sw;
    logic       pause;

    logic [9:0] x_offset;
    logic       show_player;
    logic [3:0] speed_cur;
    logic       dir_cur;
    logic       frame_tick;

    modport master (
        output vsync,
        output speed_sw,
        output dir_sw,
        output pause,
        input  x_offset,
        input  show_player,
        input  speed_cur,
        input  dir_cur,
        input  frame_tick
    );

    modport slave (
        input  vsync,
        input  speed_sw,
        input  dir_sw,
        input  pause,
        output x_offset,
        output show_player,
        output speed_cur,
        output dir_cur,
        output frame_tick
    );
endinterface

// File: rtl/anim_scheduler.sv
// anim_scheduler: once per video frame, advances a wrapped scroll offset at a
// speed that ramps toward the switch setting, and performs direction changes
// by decelerating to zero, turning, and ramping back up.
module anim_scheduler #(
    parameter int WRAP        = 400,
    parameter int RAMP_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    anim_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DECEL,
        ST_TURN
    } state_t;

    localparam logic [10:0] WRAP_W    = 11'(WRAP);
    localparam logic [3:0]  RAMP_LAST = 4'(RAMP_FRAMES - 1);
    localparam logic [3:0]  SPEED_RST = 4'd4;

    // Input synchronizers and vsync edge detector
    logic [3:0] speed_meta_q, speed_meta_d;
    logic [3:0] speed_sync_q, speed_sync_d;
    logic       dir_meta_q, dir_meta_d;
    logic       dir_sync_q, dir_sync_d;
    logic       pause_meta_q, pause_meta_d;
    logic       pause_sync_q, pause_sync_d;
    logic       vsync_prev_q, vsync_prev_d;
    logic       frame_tick_q, frame_tick_d;

    // Frame-rate state
    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic       show_q, show_d;
    logic [3:0] speed_q, speed_d;
    logic       dir_q, dir_d;
    logic [3:0] ramp_q, ramp_d;

    // Per-tick arithmetic
    logic        tick_en;
    logic        step;
    logic [3:0]  tgt;
    logic [3:0]  speed_toward;
    logic [3:0]  speed_dec;
    logic [10:0] x_wide;
    logic [10:0] s_wide;
    logic [10:0] fwd_sum;
    logic [10:0] fwd_x;
    logic [10:0] rev_x;
    logic [9:0]  x_next;

    // Two-stage synchronizer chains and the vsync rising-edge detector
    always_comb begin
        speed_meta_d = bus.speed_sw;
        speed_sync_d = speed_meta_q;
        dir_meta_d   = bus.dir_sw;
        dir_sync_d   = dir_meta_q;
        pause_meta_d = bus.pause;
        pause_sync_d = pause_meta_q;
        vsync_prev_d = bus.vsync;
        frame_tick_d = bus.vsync & ~vsync_prev_q;
    end

    // Front-end registers; reset clears the synchronizers and the vsync history
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_meta_q <= 4'd0;
            speed_sync_q <= 4'd0;
            dir_meta_q   <= 1'b0;
            dir_sync_q   <= 1'b0;
            pause_meta_q <= 1'b0;
            pause_sync_q <= 1'b0;
            vsync_prev_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            speed_meta_q <= speed_meta_d;
            speed_sync_q <= speed_sync_d;
            dir_meta_q   <= dir_meta_d;
            dir_sync_q   <= dir_sync_d;
            pause_meta_q <= pause_meta_d;
            pause_sync_q <= pause_sync_d;
            vsync_prev_q <= vsync_prev_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Target speed, single-step speed moves and the wrapped offset advance
    always_comb begin
        tick_en = frame_tick_q & ~pause_sync_q;
        step    = (ramp_q == RAMP_LAST);
        tgt     = (speed_sync_q == 4'd0) ? 4'd1 : speed_sync_q;

        if (speed_q < tgt) begin
            speed_toward = speed_q + 4'd1;
        end else if (speed_q > tgt) begin
            speed_toward = speed_q - 4'd1;
        end else begin
            speed_toward = speed_q;
        end

        speed_dec = (speed_q == 4'd0) ? 4'd0 : speed_q - 4'd1;

        x_wide  = {1'b0, x_q};
        s_wide  = {7'd0, speed_q};
        fwd_sum = x_wide + s_wide;
        fwd_x   = (fwd_sum >= WRAP_W) ? fwd_sum - WRAP_W : fwd_sum;
        rev_x   = (x_wide >= s_wide) ? x_wide - s_wide : x_wide + WRAP_W - s_wide;
        x_next  = dir_q ? 10'(rev_x) : 10'(fwd_x);
    end

    // Next state and datapath values; everything holds except on unpaused ticks
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        show_d  = show_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        ramp_d  = ramp_q;

        if (tick_en) begin
            ramp_d = step ? 4'd0 : ramp_q + 4'd1;

            unique case (state_q)
                ST_INIT: begin
                    state_d = ST_RUN;
                    show_d  = 1'b1;
                end
                ST_RUN: begin
                    x_d = x_next;
                    if (step) begin
                        speed_d = speed_toward;
                    end
                    if (dir_sync_q != dir_q) begin
                        state_d = ST_DECEL;
                    end
                end
                ST_DECEL: begin
                    x_d = x_next;
                    if (step) begin
                        speed_d = speed_dec;
                    end
                    if (dir_sync_q == dir_q) begin
                        state_d = ST_RUN;
                    end else if (speed_q == 4'd0) begin
                        state_d = ST_TURN;
                    end
                end
                ST_TURN: begin
                    x_d     = x_next;
                    speed_d = 4'd0;
                    dir_d   = ~dir_q;
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // Frame-rate state register; reset abandons any turn in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            x_q     <= 10'd0;
            show_q  <= 1'b0;
            speed_q <= SPEED_RST;
            dir_q   <= 1'b0;
            ramp_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            show_q  <= show_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            ramp_q  <= ramp_d;
        end
    end

    assign bus.x_offset    = x_q;
    assign bus.show_player = show_q;
    assign bus.speed_cur   = speed_q;
    assign bus.dir_cur     = dir_q;
    assign bus.frame_tick  = frame_tick_q;

endmodule
